pwm_capture_hl: RTL

//  Decoder for centre-aligned complementary PWM (h/l pair) produced by our PWM cores.

---
 rtl/pwm_capture_hl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture_hl.sv
// rtl/pwm_capture_hl.sv - centre-aligned complementary PWM decoder with period and shoot-through checks
module pwm_capture_hl #(
    parameter int k   = 14,
    parameter int tol = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_in,
    input  logic        l_in,
    input  logic        fault_clr,
    output logic [15:0] val_out,
    output logic        val_valid,
    output logic        period_err,
    output logic        fault
);

    localparam int             W       = k + 2;
    localparam logic [W-1:0]   NOM     = W'(1) << (k + 1);
    localparam logic [W-1:0]   PMIN    = NOM - W'(tol);
    localparam logic [W-1:0]   PMAX    = NOM + W'(tol);
    localparam logic [k-1:0]   HALF    = k'(1) << (k - 1);
    localparam logic [k-1:0]   S_MAX   = {1'b0, {(k - 1){1'b1}}};
    localparam logic [15:0]    MAX_POS = 16'(S_MAX) << (16 - k);
    localparam logic [15:0]    MAX_NEG = 16'h8000;

    typedef enum logic {ACQ, RUN} state_t;

    logic         h_meta_q, h_s_q, h_s_dly_q;
    logic         l_meta_q, l_s_q;
    logic [W-1:0] p_q, p_d;
    logic [W-1:0] hcnt_q, hcnt_d;
    state_t       state_q;
    logic [15:0]  val_out_q;
    logic         val_valid_q, period_err_q, fault_q;

    logic         rise, timeout, in_tol;
    logic [k-1:0] s_k;
    logic [15:0]  meas_val;

    assign rise    = h_s_q & ~h_s_dly_q;
    // A rise on the threshold cycle is a real edge, so it suppresses the timeout.
    assign timeout = ~rise & (p_q >= PMAX);
    assign in_tol  = (p_q >= PMIN) && (p_q <= PMAX);

    // Two-flop synchronizers for both inputs plus the edge-detect delay on h.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_meta_q  <= 1'b0;
            h_s_q     <= 1'b0;
            h_s_dly_q <= 1'b0;
            l_meta_q  <= 1'b0;
            l_s_q     <= 1'b0;
        end else begin
            h_meta_q  <= h_in;
            h_s_q     <= h_meta_q;
            h_s_dly_q <= h_s_q;
            l_meta_q  <= l_in;
            l_s_q     <= l_meta_q;
        end
    end

    // Period and high-time counters; the rise (or timeout) cycle itself is counted.
    always_comb begin
        p_d    = p_q;
        hcnt_d = hcnt_q;
        if (rise || timeout) begin
            p_d    = W'(1);
            hcnt_d = W'(h_s_q);
        end else begin
            if (p_q != '1) begin
                p_d = p_q + W'(1);
            end
            if (h_s_q && (hcnt_q != '1)) begin
                hcnt_d = hcnt_q + W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q    <= '0;
            hcnt_q <= '0;
        end else begin
            p_q    <= p_d;
            hcnt_q <= hcnt_d;
        end
    end

    // High time to signed command: v = H/2 centred on 2^(k-1), clipped at full duty.
    always_comb begin
        if (hcnt_q >= NOM) begin
            s_k = S_MAX;
        end else begin
            s_k = hcnt_q[k:1] - HALF;
        end
        meas_val = 16'(s_k) << (16 - k);
    end

    // Acquisition FSM with registered value and strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACQ;
            val_out_q    <= '0;
            val_valid_q  <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            val_valid_q  <= 1'b0;
            period_err_q <= 1'b0;
            if (rise) begin
                case (state_q)
                    ACQ: state_q <= RUN;
                    RUN: begin
                        if (in_tol) begin
                            val_out_q   <= meas_val;
                            val_valid_q <= 1'b1;
                        end else begin
                            period_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ACQ;
                endcase
            end else if (timeout) begin
                val_out_q   <= h_s_q ? MAX_POS : MAX_NEG;
                val_valid_q <= 1'b1;
                state_q     <= ACQ;
            end
        end
    end

    // Sticky shoot-through flag; an overlap in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (h_s_q && l_s_q) begin
            fault_q <= 1'b1;
        end else if (fault_clr) begin
            fault_q <= 1'b0;
        end
    end

    assign val_out    = val_out_q;
    assign val_valid  = val_valid_q;
    assign period_err = period_err_q;
    assign fault      = fault_q;

endmodule
